drv_ad56x3_feeder: RTL and testbench

- Upstream stage of the AD56x3 DAC interface core.
- Buffers paired channel-A/channel-B samples from an arbitrary-rate producer (DMA, DDS, CPU bridge) in a synchronous FIFO.
- Presents each pair to the core's two Avalon-ST sinks simultaneously.
- Tracks fill level and counts underruns, i.e. DAC update slots missed because the buffer was empty.

---
 rtl/drv_ad56x3_feeder_pkg.sv | 15 +
 rtl/drv_ad56x3_feeder_if.sv | 32 +++
 rtl/drv_ad56x3_feeder_sync_fifo_ram.sv | 23 ++
 rtl/drv_ad56x3_feeder.sv | 131 +++++++++++++
 tb/tb_drv_ad56x3_feeder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/drv_ad56x3_feeder_pkg.sv
// Shared types and elaboration helpers for the AD56x3 sample-pair feeder.
package drv_ad56x3_feeder_pkg;

  localparam int DATA_WIDTH = 14;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } sample_pair_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/drv_ad56x3_feeder_if.sv
// Producer sink, dual core sources, control and status of the feeder.
interface drv_ad56x3_feeder_if #(
  parameter int DATA_WIDTH = 14,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  snkValid;
  logic [DATA_WIDTH-1:0] snkDataA;
  logic [DATA_WIDTH-1:0] snkDataB;
  logic                  snkRdy;
  logic                  srcValid0;
  logic [DATA_WIDTH-1:0] srcData0;
  logic                  srcRdy0;
  logic                  srcValid1;
  logic [DATA_WIDTH-1:0] srcData1;
  logic                  flush;
  logic                  clrStats;
  logic [LW-1:0]         level;
  logic [CNT_WIDTH-1:0]  underrunCnt;

  modport master (
    output snkValid, snkDataA, snkDataB, srcRdy0, flush, clrStats,
    input  snkRdy, srcValid0, srcData0, srcValid1, srcData1, level, underrunCnt
  );

  modport slave (
    input  snkValid, snkDataA, snkDataB, srcRdy0, flush, clrStats,
    output snkRdy, srcValid0, srcData0, srcValid1, srcData1, level, underrunCnt
  );
endinterface

// File: rtl/drv_ad56x3_feeder_sync_fifo_ram.sv
// Single-clock simple dual-port RAM with registered read port.
module sync_fifo_ram #(
  parameter int AW = 4,
  parameter int W  = 28
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/drv_ad56x3_feeder.sv
// FWFT sample-pair FIFO feeding both AD56x3 core channels, with underrun stats.
// Optional hold-last-sample on empty: define DRV_AD56X3_FEEDER_REPEAT_EN.
module drv_ad56x3_feeder
  import drv_ad56x3_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                reset,
  drv_ad56x3_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_chk
    $error("DEPTH must be a power of two >= 2");
  end

  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 snk_rdy_q, snk_rdy_d;
  logic                 out_vld_q, out_vld_d;
  logic                 sel_ram_q, sel_ram_d;
  logic [PW-1:0]        byp_q, byp_d;
  logic                 rdy_q;
  logic [CNT_WIDTH-1:0] ucnt_q, ucnt_d;
  logic [PW-1:0]        ram_rdata, out_pair;
  logic push, pop, ram_empty, out_free, load_ram, load_byp, ram_we, underrun;

  assign push      = bus.snkValid & snk_rdy_q;
  assign pop       = out_vld_q & bus.srcRdy0;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign out_free  = ~out_vld_q | pop;
  // Output register is refilled from RAM first; the RAM is bypassed only when it holds nothing.
  assign load_ram  = out_free & ~ram_empty & ~bus.flush;
  assign load_byp  = out_free & ram_empty & push & ~bus.flush;
  assign ram_we    = push & ~(out_free & ram_empty) & ~bus.flush;
  assign underrun  = bus.srcRdy0 & ~rdy_q & ~out_vld_q;

  sync_fifo_ram #(.AW(AW), .W(PW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({bus.snkDataA, bus.snkDataB}),
    .re_i    (load_ram),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    snk_rdy_d = snk_rdy_q;
    out_vld_d = out_vld_q;
    sel_ram_d = sel_ram_q;
    byp_d     = byp_q;
    ucnt_d    = ucnt_q;
    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      snk_rdy_d = 1'b1;
      out_vld_d = 1'b0;
      sel_ram_d = 1'b0;
      byp_d     = '0;
    end else begin
      if (ram_we)   wr_ptr_d = wr_ptr_q + LW'(1);
      if (load_ram) rd_ptr_d = rd_ptr_q + LW'(1);
      out_vld_d = (out_vld_q & ~pop) | load_ram | load_byp;
      if (load_ram)      sel_ram_d = 1'b1;
      else if (load_byp) sel_ram_d = 1'b0;
      if (load_byp) byp_d = {bus.snkDataA, bus.snkDataB};
      level_d   = level_q + LW'(push) - LW'(pop);
      snk_rdy_d = (level_d < FULL_LVL);
    end
    if (bus.clrStats)             ucnt_d = '0;
    else if (underrun && ~&ucnt_q) ucnt_d = ucnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      snk_rdy_q <= 1'b0;
      out_vld_q <= 1'b0;
      sel_ram_q <= 1'b0;
      byp_q     <= '0;
      rdy_q     <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      snk_rdy_q <= snk_rdy_d;
      out_vld_q <= out_vld_d;
      sel_ram_q <= sel_ram_d;
      byp_q     <= byp_d;
      rdy_q     <= bus.srcRdy0;
      ucnt_q    <= ucnt_d;
    end
  end

  assign out_pair = sel_ram_q ? ram_rdata : byp_q;

`ifdef DRV_AD56X3_FEEDER_REPEAT_EN
  // Output register keeps the last popped pair untouched, so repeating only needs a valid flag.
  logic rep_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rep_q <= 1'b0;
    else if (bus.flush) rep_q <= 1'b0;
    else if (pop)       rep_q <= 1'b1;
  end
  assign bus.srcValid0 = out_vld_q | rep_q;
  assign bus.srcValid1 = out_vld_q | rep_q;
`else
  assign bus.srcValid0 = out_vld_q;
  assign bus.srcValid1 = out_vld_q;
`endif

  assign bus.srcData0   = out_pair[PW-1:DATA_WIDTH];
  assign bus.srcData1   = out_pair[DATA_WIDTH-1:0];
  assign bus.snkRdy     = snk_rdy_q;
  assign bus.level      = level_q;
  assign bus.underrunCnt = ucnt_q;
endmodule

// File: tb/tb_drv_ad56x3_feeder.sv
// Directed bench for drv_ad56x3_feeder with a queue scoreboard of expected pairs.
module tb_drv_ad56x3_feeder;
  import drv_ad56x3_feeder_pkg::*;

  localparam int DW = 14;
  localparam int DEP = 16;
  localparam int CW = 16;

  logic clk, reset;
  int checks = 0, failures = 0;

  drv_ad56x3_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEP), .CNT_WIDTH(CW)) bus ();

  drv_ad56x3_feeder #(.DATA_WIDTH(DW), .DEPTH(DEP), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sample_pair_t q[$];
  sample_pair_t m_held;
  bit m_rdy, m_prev, m_rep;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic cyc(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input bit r, input bit fl = 1'b0, input bit cl = 1'b0);
    bit ev, psh, pp, ur;
    sample_pair_t ed, np;
    ev = (q.size() > 0) || m_rep;
    ed = (q.size() > 0) ? q[0] : m_held;
    chk("snkRdy", bus.snkRdy, m_rdy);
    chk("level", bus.level, q.size());
    chk("srcValid0", bus.srcValid0, ev);
    chk("srcValid1", bus.srcValid1, ev);
    if (ev) begin
      chk("srcData0", bus.srcData0, ed.a);
      chk("srcData1", bus.srcData1, ed.b);
    end
    chk("underrunCnt", bus.underrunCnt, m_cnt);
    bus.snkValid = v; bus.snkDataA = a; bus.snkDataB = b;
    bus.srcRdy0 = r; bus.flush = fl; bus.clrStats = cl;
    ur  = r && !m_prev && (q.size() == 0);
    psh = v && m_rdy;
    pp  = r && (q.size() > 0);
    if (fl) begin
      q.delete(); m_rep = 1'b0; m_held = '0; m_rdy = 1'b1;
    end else begin
      if (pp) begin
        m_held = q.pop_front();
`ifdef DRV_AD56X3_FEEDER_REPEAT_EN
        m_rep = 1'b1;
`endif
      end
      if (psh) begin np.a = a; np.b = b; q.push_back(np); end
      m_rdy = (q.size() < DEP);
    end
    if (cl) m_cnt = 0;
    else if (ur && m_cnt != 65535) m_cnt++;
    m_prev = r;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_snkRdy"}, bus.snkRdy, 0);
    chk({pfx, "_srcValid0"}, bus.srcValid0, 0);
    chk({pfx, "_srcValid1"}, bus.srcValid1, 0);
    chk({pfx, "_srcData0"}, bus.srcData0, 0);
    chk({pfx, "_srcData1"}, bus.srcData1, 0);
    chk({pfx, "_level"}, bus.level, 0);
    chk({pfx, "_underrunCnt"}, bus.underrunCnt, 0);
  endtask

  task automatic do_reset();
    bus.snkValid = 0; bus.snkDataA = '0; bus.snkDataB = '0;
    bus.srcRdy0 = 0; bus.flush = 0; bus.clrStats = 0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_zero("rst");
    q.delete(); m_rdy = 0; m_prev = 0; m_cnt = 0; m_rep = 0; m_held = '0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

    // Three pushes into an empty FIFO, core stalled
    cyc(1, 14'h0001, 14'h1001, 0);
    chk("t1_valid", bus.srcValid0, 1);
    chk("t1_d0", bus.srcData0, 14'h0001);
    chk("t1_d1", bus.srcData1, 14'h1001);
    cyc(1, 14'h0002, 14'h1002, 0);
    cyc(1, 14'h0003, 14'h1003, 0);
    chk("t1_level", bus.level, 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Fill to full, 17th pair held until a slot frees
    for (int i = 0; i < DEP; i++) cyc(1, 14'(i + 16), 14'(14'h2000 + i), 0);
    chk("t2_level_full", bus.level, DEP);
    chk("t2_snkRdy_full", bus.snkRdy, 0);
    cyc(1, 14'h3111, 14'h3222, 0);
    cyc(1, 14'h3111, 14'h3222, 0);
    chk("t2_level_hold", bus.level, DEP);
    cyc(1, 14'h3111, 14'h3222, 1);
    chk("t2_snkRdy_free", bus.snkRdy, 1);
    cyc(1, 14'h3111, 14'h3222, 0);
    chk("t2_level_refill", bus.level, DEP);
    for (int i = 0; i < DEP + 2; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Streaming with the core always ready
    for (int i = 0; i < 20; i++) begin
      cyc(1, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1);
      chk("t3_level_le1", {31'b0, bus.level <= 5'd1}, 1);
    end
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);

    // Simultaneous push and pop with backlog in RAM
    for (int i = 0; i < 3; i++) cyc(1, 14'(14'h0100 + i), 14'(14'h0200 + i), 0);
    for (int i = 0; i < 6; i++) cyc(1, 14'(14'h0110 + i), 14'(14'h0210 + i), 1);
    chk("t3b_level", bus.level, 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Underrun: one count per rising edge, not per ready cycle
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_cleared", bus.underrunCnt, 0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    end
    chk("t4_count3", bus.underrunCnt, 3);
    cyc(0, 0, 0, 1, 0, 1);
    chk("t4_clr_priority", bus.underrunCnt, 0);
    cyc(0, 0, 0, 0);

    // Flush with a concurrent push drops everything
    for (int i = 0; i < 5; i++) cyc(1, 14'(14'h0500 + i), 14'(14'h0600 + i), 0);
    cyc(1, 14'h3ABC, 14'h1234, 0, 1);
    chk("t5_level", bus.level, 0);
    chk("t5_valid", bus.srcValid0, 0);
    chk("t5_snkRdy", bus.snkRdy, 1);
    cyc(1, 14'h0777, 14'h0888, 0);
    cyc(1, 14'h0779, 14'h0889, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);

    // Single pair then repeated core slots on an empty FIFO
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 14'h0ABC, 14'h0DEF, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
`ifdef DRV_AD56X3_FEEDER_REPEAT_EN
      chk("t6_rep_valid", bus.srcValid0, 1);
      chk("t6_rep_d0", bus.srcData0, 14'h0ABC);
      chk("t6_rep_d1", bus.srcData1, 14'h0DEF);
`else
      chk("t6_empty_valid", bus.srcValid0, 0);
`endif
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    end
    chk("t6_count3", bus.underrunCnt, 3);
    chk("t6_level0", bus.level, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) cyc(1, 14'(14'h0900 + i), 14'(14'h0A00 + i), 0);
    reset = 1'b1;
    #1;
    chk_zero("arst");
    do_reset();
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
